cache_arbiter: RTL and testbench
================================

# cache_arbiter

Arbitrates the shared physical-memory port between the split L1 instruction cache (port A, feeding the fetch-side `mem_resp_a` of the pipeline) and the L1 data cache (port B, serving `mem_read_b`/`mem_write_b`). Each L1 miss or writeback is serialised onto one line-wide memory bus. Ties are resolved by alternating priority, so a stalled pipeline cannot starve either port. The block sits between the two L1 caches and the L2/physical memory.

## Interface
- `LINE_W`, default 128: cache line width in bits.
- `ADDR_W`, default 16: byte address width (`lc3b_word`).
- `clk` input 1: system clock; all state updates on its rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `a_pmem_read` input 1: I-cache line read request, held until `a_pmem_resp`.
- `a_pmem_address` input ADDR_W: I-cache line address.
- `a_pmem_rdata` output LINE_W: line returned to the I-cache.
- `a_pmem_resp` output 1: one-cycle completion pulse to the I-cache.
- `b_pmem_read` input 1: D-cache line read request.
- `b_pmem_write` input 1: D-cache line writeback request.
- `b_pmem_address` input ADDR_W: D-cache line address.
- `b_pmem_wdata` input LINE_W: writeback line.
- `b_pmem_rdata` output LINE_W: line returned to the D-cache.
- `b_pmem_resp` output 1: one-cycle completion pulse to the D-cache.
- `pmem_read` output 1: read request to memory.
- `pmem_write` output 1: write request to memory.
- `pmem_address` output ADDR_W: memory address.
- `pmem_wdata` output LINE_W: memory write data.
- `pmem_rdata` input LINE_W: memory read data.
- `pmem_resp` input 1: memory completion pulse.

## Operation

**States**
- `IDLE`: no transaction in progress.
- `GRANT_A`: serving the I-cache read.
- `GRANT_B`: serving a D-cache read or writeback.

**Latching at grant**
- On leaving `IDLE`, latch into holding registers: address, wdata, and an `op_write` bit.
- `pmem_address` and `pmem_wdata` are driven from these registers only. Requester changes mid-transaction have no effect.

**Arbitration in `IDLE`**
- Pending is `req_a = a_pmem_read` and `req_b = b_pmem_read | b_pmem_write`.
- If only one port is pending, grant it.
- If both are pending, grant the port that was not named by the `last_grant` register.
- `last_grant` updates on every grant. Its reset value is A, so B wins the first tie.

**Request conflicts**
- `b_pmem_read` and `b_pmem_write` both high is a protocol violation. The write wins (`op_write=1`).

**In a grant state**
- `pmem_read = !op_write` and `pmem_write = op_write`, held until `pmem_resp`.
- When `pmem_resp` is high:
  - Pulse the granted port's `*_resp` in the same cycle (combinational).
  - Pass `pmem_rdata` through to that port's `*_rdata`.
  - Next state is `IDLE`.
- The ungranted port's `*_resp` stays 0.

**Withdrawn or illegal activity**
- A request withdrawn after grant cannot abort memory. The transaction completes and `*_resp` still pulses; the requester ignores it.
- `pmem_resp` while in `IDLE` is ignored.

**Reset**
- `reset_n` low at any edge forces the next state to `IDLE`, `last_grant=A`, and clears the holding registers. This applies mid-transaction too.
- Outputs after reset: `pmem_read=0`, `pmem_write=0`, `pmem_address=0`, `pmem_wdata=0`, `a_pmem_resp=0`, `b_pmem_resp=0`.
- `*_rdata` outputs mirror `pmem_rdata` at all times.

## Timing
- Request first seen in `IDLE` at cycle 0: grant state and `pmem_read`/`pmem_write` asserted at cycle 1.
- `pmem_resp` at cycle k: `*_resp` at cycle k, `IDLE` at cycle k+1.
- Earliest next grant is cycle k+2. The mandatory `IDLE` cycle lets the requester drop its request after `*_resp`.
- Minimum round trip with single-cycle memory: request at cycle 0, resp at cycle 1.
- `pmem_read`/`pmem_write` never toggle inside a transaction and are never both high.

## Test plan
- **Reset:** hold `reset_n=0` 3 cycles with `a_pmem_read=1` -> all outputs 0. Release -> `pmem_read=1` one cycle later, `pmem_address` = A address.
- **Single A read:** `a_pmem_address=0x1230`, memory responds after 4 cycles with `rdata=0xDEADBEEF…` -> `a_pmem_resp` pulses exactly 1 cycle with that data. `b_pmem_resp` stays 0.
- **Tie and alternation:** A read and B write (`0x4000`, `wdata=0x55…`) both raised at cycle 0 -> B served first (`pmem_write=1`), then A. Repeat the tie -> A first.
- **Address hold:** change `b_pmem_address` from `0x4000` to `0x5000` mid-transaction -> `pmem_address` stays `0x4000` until resp.
- **Illegal B read and write:** `b_pmem_read=b_pmem_write=1` -> `pmem_write=1`, `pmem_read=0`.
- **Reset mid-transaction:** `reset_n=0` during `GRANT_B` -> `pmem_write=0` after the edge. After release with `a_pmem_read` and `b_pmem_read` both high -> B granted first.

Source files
------------

// File: rtl/cache_arbiter.sv
// Shares one line-wide physical-memory port between the I-cache (A) and D-cache (B).
// Ties alternate via last_grant; address/data/op are frozen at grant time.
module cache_arbiter #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_pmem_read,
    input  logic [ADDR_W-1:0] a_pmem_address,
    output logic [LINE_W-1:0] a_pmem_rdata,
    output logic              a_pmem_resp,
    input  logic              b_pmem_read,
    input  logic              b_pmem_write,
    input  logic [ADDR_W-1:0] b_pmem_address,
    input  logic [LINE_W-1:0] b_pmem_wdata,
    output logic [LINE_W-1:0] b_pmem_rdata,
    output logic              b_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_b_q, last_b_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic                op_write_q, op_write_d;

    logic req_a, req_b, pick_a, pick_b;

    assign req_a  = a_pmem_read;
    assign req_b  = b_pmem_read | b_pmem_write;
    // On a tie the port that did not win last time goes next.
    assign pick_b = req_b & (~req_a | ~last_b_q);
    assign pick_a = req_a & ~pick_b;

    always_comb begin
        state_d     = state_q;
        last_b_d    = last_b_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        op_write_d  = op_write_q;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        a_pmem_resp = 1'b0;
        b_pmem_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_b) begin
                    state_d    = GRANT_B;
                    last_b_d   = 1'b1;
                    addr_d     = b_pmem_address;
                    wdata_d    = b_pmem_wdata;
                    op_write_d = b_pmem_write;
                end else if (pick_a) begin
                    state_d    = GRANT_A;
                    last_b_d   = 1'b0;
                    addr_d     = a_pmem_address;
                    wdata_d    = '0;
                    op_write_d = 1'b0;
                end
            end
            GRANT_A, GRANT_B: begin
                pmem_read  = ~op_write_q;
                pmem_write = op_write_q;
                if (pmem_resp) begin
                    a_pmem_resp = (state_q == GRANT_A);
                    b_pmem_resp = (state_q == GRANT_B);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_write_q <= op_write_d;
        end
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign a_pmem_rdata = pmem_rdata;
    assign b_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_cache_arbiter;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              a_pmem_read;
    logic [ADDR_W-1:0] a_pmem_address;
    logic [LINE_W-1:0] a_pmem_rdata;
    logic              a_pmem_resp;
    logic              b_pmem_read;
    logic              b_pmem_write;
    logic [ADDR_W-1:0] b_pmem_address;
    logic [LINE_W-1:0] b_pmem_wdata;
    logic [LINE_W-1:0] b_pmem_rdata;
    logic              b_pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_pmem_read(a_pmem_read), .a_pmem_address(a_pmem_address),
        .a_pmem_rdata(a_pmem_rdata), .a_pmem_resp(a_pmem_resp),
        .b_pmem_read(b_pmem_read), .b_pmem_write(b_pmem_write),
        .b_pmem_address(b_pmem_address), .b_pmem_wdata(b_pmem_wdata),
        .b_pmem_rdata(b_pmem_rdata), .b_pmem_resp(b_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction in flight: owner 0 = none, 1 = I-cache, 2 = D-cache.
    int                m_owner = 0;
    bit                m_last_b = 1'b0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [LINE_W-1:0] m_wdata = '0;
    bit                m_wr    = 1'b0;

    logic              last_a_resp, last_b_resp;
    logic [LINE_W-1:0] last_a_rdata;
    int                a_cnt, b_cnt;

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare DUT outputs with the model for the current cycle, then advance one clock.
    task automatic step();
        int                n_owner;
        bit                n_last_b, n_wr, ra, rb, take_b;
        logic [ADDR_W-1:0] n_addr;
        logic [LINE_W-1:0] n_wdata;
        #1;
        check("pmem_read",  LINE_W'(pmem_read),  LINE_W'(m_owner != 0 && !m_wr));
        check("pmem_write", LINE_W'(pmem_write), LINE_W'(m_owner != 0 && m_wr));
        check("pmem_address", LINE_W'(pmem_address), LINE_W'(m_addr));
        check("pmem_wdata", pmem_wdata, m_wdata);
        check("a_resp", LINE_W'(a_pmem_resp), LINE_W'(m_owner == 1 && pmem_resp));
        check("b_resp", LINE_W'(b_pmem_resp), LINE_W'(m_owner == 2 && pmem_resp));
        check("a_rdata", a_pmem_rdata, pmem_rdata);
        check("b_rdata", b_pmem_rdata, pmem_rdata);
        last_a_resp  = a_pmem_resp;
        last_b_resp  = b_pmem_resp;
        last_a_rdata = a_pmem_rdata;
        if (a_pmem_resp === 1'b1) a_cnt++;
        if (b_pmem_resp === 1'b1) b_cnt++;

        n_owner = m_owner; n_last_b = m_last_b; n_addr = m_addr; n_wdata = m_wdata; n_wr = m_wr;
        if (!reset_n) begin
            n_owner = 0; n_last_b = 1'b0; n_addr = '0; n_wdata = '0; n_wr = 1'b0;
        end else if (m_owner != 0) begin
            if (pmem_resp) n_owner = 0;
        end else begin
            ra = a_pmem_read;
            rb = b_pmem_read | b_pmem_write;
            if (ra || rb) begin
                take_b = rb && !(ra && m_last_b);
                n_owner  = take_b ? 2 : 1;
                n_last_b = take_b;
                n_addr   = take_b ? b_pmem_address : a_pmem_address;
                n_wdata  = take_b ? b_pmem_wdata : '0;
                n_wr     = take_b && b_pmem_write;
            end
        end
        @(posedge clk);
        #1;
        m_owner = n_owner; m_last_b = n_last_b; m_addr = n_addr; m_wdata = n_wdata; m_wr = n_wr;
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    int mem_wait;
    bit mem_active;

    initial begin
        reset_n = 1'b0;
        a_pmem_read = 1'b0; a_pmem_address = '0;
        b_pmem_read = 1'b0; b_pmem_write = 1'b0; b_pmem_address = '0; b_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        a_cnt = 0; b_cnt = 0;
        @(posedge clk);
        #1;

        // Reset held with a pending I-cache read, then a single A read with 4-cycle memory.
        a_pmem_read = 1'b1; a_pmem_address = 16'h1230;
        repeat (3) step();
        check("rst_pmem_read", LINE_W'(pmem_read), '0);
        check("rst_pmem_address", LINE_W'(pmem_address), '0);
        reset_n = 1'b1;
        step();
        check("rel_pmem_read", LINE_W'(pmem_read), LINE_W'(1));
        check("rel_pmem_address", LINE_W'(pmem_address), LINE_W'(16'h1230));
        a_cnt = 0; b_cnt = 0;
        repeat (3) step();
        pmem_resp = 1'b1; pmem_rdata = {4{32'hDEADBEEF}};
        step();
        check("a_read_rdata", last_a_rdata, {4{32'hDEADBEEF}});
        a_pmem_read = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0;
        repeat (2) step();
        check("a_read_resp_count", LINE_W'(a_cnt), LINE_W'(1));
        check("a_read_b_resp_count", LINE_W'(b_cnt), '0);

        // Tie: B wins first; B re-requests at once so the next tie goes to A.
        a_pmem_read = 1'b1; a_pmem_address = 16'h2000;
        b_pmem_write = 1'b1; b_pmem_address = 16'h4000; b_pmem_wdata = {16{8'h55}};
        step();
        check("tie1_b_write", LINE_W'(pmem_write), LINE_W'(1));
        check("tie1_b_addr", LINE_W'(pmem_address), LINE_W'(16'h4000));
        b_pmem_address = 16'h5000;
        step();
        check("addr_hold", LINE_W'(pmem_address), LINE_W'(16'h4000));
        check("wdata_hold", pmem_wdata, {16{8'h55}});
        pmem_resp = 1'b1; pmem_rdata = rnd_line();
        step();
        check("tie1_b_resp", LINE_W'(last_b_resp), LINE_W'(1));
        pmem_resp = 1'b0; b_pmem_address = 16'h4010;
        step();
        check("tie2_a_first", LINE_W'(pmem_read), LINE_W'(1));
        check("tie2_a_addr", LINE_W'(pmem_address), LINE_W'(16'h2000));
        pmem_resp = 1'b1;
        step();
        check("tie2_a_resp", LINE_W'(last_a_resp), LINE_W'(1));
        a_pmem_read = 1'b0; pmem_resp = 1'b0;
        step();
        check("tie2_b_next", LINE_W'(pmem_address), LINE_W'(16'h4010));
        pmem_resp = 1'b1;
        step();
        b_pmem_write = 1'b0; pmem_resp = 1'b0;
        step();

        // Read and write together: the write wins.
        b_pmem_read = 1'b1; b_pmem_write = 1'b1; b_pmem_address = 16'h6000;
        step();
        check("illegal_write", LINE_W'(pmem_write), LINE_W'(1));
        check("illegal_no_read", LINE_W'(pmem_read), '0);
        pmem_resp = 1'b1;
        step();
        b_pmem_read = 1'b0; b_pmem_write = 1'b0; pmem_resp = 1'b0;
        step();

        // Reset in the middle of a B writeback.
        b_pmem_write = 1'b1; b_pmem_address = 16'h7000;
        step();
        check("mid_grant_write", LINE_W'(pmem_write), LINE_W'(1));
        reset_n = 1'b0;
        a_pmem_read = 1'b1; a_pmem_address = 16'h1000;
        b_pmem_write = 1'b0; b_pmem_read = 1'b1; b_pmem_address = 16'h7100;
        step();
        check("mid_rst_write", LINE_W'(pmem_write), '0);
        check("mid_rst_addr", LINE_W'(pmem_address), '0);
        reset_n = 1'b1;
        step();
        check("post_rst_b_first", LINE_W'(pmem_address), LINE_W'(16'h7100));
        pmem_resp = 1'b1;
        step();
        b_pmem_read = 1'b0; pmem_resp = 1'b0;
        step();
        pmem_resp = 1'b1;
        step();
        a_pmem_read = 1'b0; pmem_resp = 1'b0;
        step();

        // Random traffic.
        mem_active = 1'b0; mem_wait = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            if (a_pmem_read && (last_a_resp || $urandom_range(0, 39) == 0)) begin
                a_pmem_read = 1'b0;
            end else if (!a_pmem_read && $urandom_range(0, 2) == 0) begin
                a_pmem_read = 1'b1;
                a_pmem_address = 16'($urandom) & 16'hFFF0;
            end
            if ((b_pmem_read || b_pmem_write) && (last_b_resp || $urandom_range(0, 39) == 0)) begin
                b_pmem_read = 1'b0; b_pmem_write = 1'b0;
            end else if (!(b_pmem_read || b_pmem_write) && $urandom_range(0, 2) == 0) begin
                int op;
                op = $urandom_range(0, 15);
                b_pmem_read  = (op < 8) || (op == 15);
                b_pmem_write = (op >= 8);
                b_pmem_address = 16'($urandom) & 16'hFFF0;
                b_pmem_wdata = rnd_line();
            end else if ($urandom_range(0, 3) == 0) begin
                b_pmem_address = 16'($urandom) & 16'hFFF0;
                b_pmem_wdata = rnd_line();
            end
            pmem_rdata = rnd_line();
            if (m_owner != 0) begin
                if (!mem_active) begin
                    mem_active = 1'b1;
                    mem_wait = $urandom_range(0, 3);
                end
                if (mem_wait == 0) begin
                    pmem_resp = 1'b1;
                    mem_active = 1'b0;
                end else begin
                    pmem_resp = 1'b0;
                    mem_wait--;
                end
            end else begin
                mem_active = 1'b0;
                pmem_resp = ($urandom_range(0, 7) == 0);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
